// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph table, digit count and types for the 7-segment scanner
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    // Active-high g..a glyphs; element [n] is the glyph for hex digit n.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// rtl/seg7_scan_display_hex_to_seg7.sv - combinational nibble to active-high 7-segment glyph
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 4-digit multiplexed 7-segment driver with blanking and frame-synchronous updates
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int PRESCALE       = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic        value_valid,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int         PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    phase_t        phase_q, phase_d;
    logic [19:0]   shadow_q, shadow_d;    // {value, dp}
    logic [19:0]   disp_q, disp_d;
    logic          pending_q, pending_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;

    logic [15:0]   disp_val;
    logic [3:0]    nibble_sel;
    logic [6:0]    glyph;
    logic [3:0]    onehot;
    logic          boundary;
    logic          suppress;

    assign disp_val   = disp_q[19:4];
    assign nibble_sel = disp_val[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_sel),
        .glyph  (glyph)
    );

    always_comb begin
        boundary = enable && (presc_q == LAST) && (idx_q == 2'd3);
        onehot   = 4'b0001 << idx_q;
        // A digit is a leading zero when it and every digit to its left are zero.
        suppress = BLANK_LEADING && (idx_q != 2'd0) && ((disp_val >> {idx_q, 2'b00}) == 16'h0000);

        presc_d = presc_q;
        idx_d   = idx_q;
        if (!enable) begin
            presc_d = '0;
            idx_d   = '0;
        end else if (presc_q == LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
        phase_d = (presc_d < BLANK_END) ? PH_BLANK : PH_DRIVE;

        shadow_d  = shadow_q;
        pending_d = pending_q;
        disp_d    = disp_q;
        if (boundary && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
        // A capture on the boundary cycle lands in shadow only, so it waits a frame.
        if (value_valid) begin
            shadow_d  = {value, dp_in};
            pending_d = 1'b1;
        end

        an_d         = AN_OFF;
        seg_d        = SEG_OFF;
        dp_d         = DP_OFF;
        frame_done_d = boundary;
        if (enable && (phase_q == PH_DRIVE)) begin
            an_d  = AN_ACTIVE_LOW ? ~onehot : onehot;
            seg_d = suppress ? SEG_OFF : (SEG_ACTIVE_LOW ? ~glyph : glyph);
            dp_d  = disp_q[idx_q] ^ SEG_ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            phase_q      <= PH_BLANK;
            shadow_q     <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - self-checking bench for seg7_scan_display against a timeline model
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] value;
    logic        value_valid;
    logic [3:0]  dp_in;
    logic [6:0]  seg, seg_nl;
    logic        dp, dp_nl;
    logic [3:0]  an, an_nl;
    logic        frame_done, frame_done_nl;

    int errors = 0;
    int checks = 0;

    bit [6:0] gly [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: m_t counts enabled cycles since scanning (re)started; slot and digit follow by division.
    int          m_t;
    logic [15:0] m_shadow_v, m_disp_v;
    logic [3:0]  m_shadow_dp, m_disp_dp;
    bit          m_pend;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg, exp_seg_nl;
    logic        exp_dp, exp_fd;

    always #5 clk = ~clk;

    seg7_scan_display #(.PRESCALE(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1),
                        .AN_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .value(value), .value_valid(value_valid),
        .dp_in(dp_in), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done));

    seg7_scan_display #(.PRESCALE(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1),
                        .AN_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_nl (
        .clk(clk), .rst(rst), .enable(enable), .value(value), .value_valid(value_valid),
        .dp_in(dp_in), .seg(seg_nl), .dp(dp_nl), .an(an_nl), .frame_done(frame_done_nl));

    task automatic model();
        int  pos, dig;
        bit  bnd;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_seg_nl = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
        if (!rst) begin
            m_t = 0; m_shadow_v = '0; m_shadow_dp = '0; m_disp_v = '0; m_disp_dp = '0; m_pend = 0;
            return;
        end
        bnd = 0;
        if (enable) begin
            pos = m_t % 8;
            dig = (m_t / 8) % 4;
            if (pos >= 2) begin
                exp_an     = ~(4'b0001 << dig);
                exp_seg_nl = ~gly[m_disp_v[4*dig +: 4]];
                exp_seg    = (dig > 0 && (m_disp_v >> (4*dig)) == 0) ? 7'h7F : exp_seg_nl;
                exp_dp     = ~m_disp_dp[dig];
            end
            bnd = (m_t % 32 == 31);
            m_t++;
        end else begin
            m_t = 0;
        end
        exp_fd = bnd;
        if (bnd && m_pend) begin
            m_disp_v = m_shadow_v; m_disp_dp = m_shadow_dp; m_pend = 0;
        end
        if (value_valid) begin
            m_shadow_v = value; m_shadow_dp = dp_in; m_pend = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
        chk("an", {4'h0, an}, {4'h0, exp_an});
        chk("seg", {1'b0, seg}, {1'b0, exp_seg});
        chk("dp", {7'h0, dp}, {7'h0, exp_dp});
        chk("frame_done", {7'h0, frame_done}, {7'h0, exp_fd});
        chk("an_nl", {4'h0, an_nl}, {4'h0, exp_an});
        chk("seg_nl", {1'b0, seg_nl}, {1'b0, exp_seg_nl});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic capture(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; value = '0; value_valid = 1'b0; dp_in = '0;
        run(2);
        rst = 1'b1; enable = 1'b1;
        run(70);

        // Mid-frame capture, then leading-zero value
        run(10);
        capture(16'h12AF, 4'b0100);
        run(60);
        capture(16'h0070, 4'b0000);
        run(70);

        // Capture exactly on the frame-boundary cycle
        for (int i = 0; i < 40 && (m_t % 32) != 31; i++) tick();
        capture(16'h0005, 4'b0001);
        run(70);

        // Drop enable mid-slot
        for (int i = 0; i < 40 && (m_t % 8) != 4; i++) tick();
        enable = 1'b0;
        run(5);
        enable = 1'b1;
        run(40);

        // Reset during DRIVE with a capture still pending
        for (int i = 0; i < 40 && (m_t % 8) != 5; i++) tick();
        capture(16'hBEEF, 4'b1111);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        run(70);

        // Randomized captures and enable drops
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: value = 16'($urandom);
                    1: value = 16'($urandom) & 16'h0FFF;
                    2: value = 16'($urandom) & 16'h00FF;
                    default: value = 16'($urandom) & 16'h000F;
                endcase
                dp_in = 4'($urandom);
                value_valid = 1'b1;
            end else begin
                value_valid = 1'b0;
            end
            enable = ($urandom_range(0, 63) != 0) ? 1'b1 : ~enable;
            tick();
        end
        value_valid = 1'b0; enable = 1'b1;
        run(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
